// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb -- register file with a per-entry busy (scoreboard) bit,
// two combinational read ports, optional write->read forwarding and a
// sequential clear sweep.
//
// Parameters
//   DATA_W   register width
//   ADDR_W   address width
//   DEPTH    number of registers (2 .. 2**ADDR_W)
//   ZERO_REG 1: register 0 is hard-wired to zero and never marked busy
//   BYPASS   1: a same-cycle valid write is forwarded to the read ports
//
// Ports
//   clk, rst                       clock, async active-high reset
//   wr_en/wr_addr/wr_data          write request (clears busy)
//   rsv_en/rsv_addr                reservation request (sets busy)
//   rd_addr1/2 -> rd_data1/2,busy1/2   combinational read ports
//   clr_req                        start a clear sweep (sampled in IDLE)
//   clr_busy                       high while the sweep runs
// ---------------------------------------------------------------------------
module reg_file_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 16,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy1,
    output logic              busy2,
    input  logic              clr_req,
    output logic              clr_busy
);

    // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
    localparam logic [ADDR_W:0]   DepthL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} clrState_t;

    clrState_t         state, stateNext;
    logic [ADDR_W-1:0] clrCnt, clrCntNext;
    logic              clearing;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic wrValid, rsvValid;

    // Address is a real, writable register (in range and not the zero reg).
    function automatic logic addrWritable(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DepthL) && !(ZERO_REG && (a == '0));
    endfunction

    assign wrValid  = wr_en  && !clearing && addrWritable(wr_addr);
    assign rsvValid = rsv_en && !clearing && addrWritable(rsv_addr);

    // ---------------- clear FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            clrCnt <= '0;
        end else begin
            state  <= stateNext;
            clrCnt <= clrCntNext;
        end
    end

    // ---------------- clear FSM: next state ----------------
    always_comb begin
        stateNext  = state;
        clrCntNext = clrCnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    stateNext  = CLEAR;
                    clrCntNext = '0;
                end
            end
            CLEAR: begin
                // clr_req is deliberately not looked at here, including on
                // the final sweep cycle.
                if (clrCnt == LastIdx) begin
                    stateNext  = IDLE;
                    clrCntNext = '0;
                end else begin
                    clrCntNext = clrCnt + 1'b1;
                end
            end
            default: begin
                stateNext  = IDLE;
                clrCntNext = '0;
            end
        endcase
    end

    // ---------------- clear FSM: outputs ----------------
    always_comb begin
        clearing = (state == CLEAR);
        clr_busy = clearing;
    end

    // ---------------- storage ----------------
    // The sweep entry takes priority; otherwise write then reservation, so
    // a same-cycle write+reserve leaves the new data with busy set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clearing && (clrCnt == ADDR_W'(i))) begin
                    mem[i]  <= '0;
                    busy[i] <= 1'b0;
                end else begin
                    if (wrValid && (wr_addr == ADDR_W'(i))) begin
                        mem[i]  <= wr_data;
                        busy[i] <= 1'b0;
                    end
                    if (rsvValid && (rsv_addr == ADDR_W'(i)))
                        busy[i] <= 1'b1;
                end
            end
        end
    end

    // ---------------- read ports ----------------
    logic [1:0][ADDR_W-1:0] rdAddr;
    logic [1:0][DATA_W-1:0] rdData;
    logic [1:0]             rdBusy;

    assign rdAddr = {rd_addr2, rd_addr1};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            rdData[p] = '0;
            rdBusy[p] = 1'b0;
            if (({1'b0, rdAddr[p]} >= DepthL) || (ZERO_REG && (rdAddr[p] == '0))) begin
                rdData[p] = '0;
                rdBusy[p] = 1'b0;
            end else if (BYPASS && wrValid && (wr_addr == rdAddr[p])) begin
                // wrValid is already false during a sweep, which disables
                // forwarding there.
                rdData[p] = wr_data;
                rdBusy[p] = rsvValid && (rsv_addr == rdAddr[p]);
            end else begin
                rdData[p] = mem[rdAddr[p]];
                rdBusy[p] = busy[rdAddr[p]];
            end
        end
    end

    assign rd_data1 = rdData[0];
    assign rd_data2 = rdData[1];
    assign busy1    = rdBusy[0];
    assign busy2    = rdBusy[1];

endmodule
